alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational 32-bit ALU between NREQ requesters (e.g. EX stage, branch-compare, address-gen).
//   Round-robin grant, valid/ready on request and response sides; one registered result buffer per block.
//   Sits between requesters and the ALU instance; drives ALU inputs, captures ALU output one cycle later.
// PARAMETERS
//   NREQ      2   number of requesters (2..4)
//   RR_RESET  0   index holding top priority after reset
// PORTS
//   clk         in   1         clock; all state on rising edge
//   rst_n       in   1         asynchronous active-low reset
//   flush       in   1         synchronous drop of held result, no accept this cycle
//   req_valid   in   NREQ      requester i has an operation
//   req_ready   out  NREQ      one-hot; operation i accepted this cycle
//   req_ctrl    in   NREQ*4    ALU op code per requester (slice i = [4i+3:4i])
//   req_src1    in   NREQ*32   operand 1 per requester
//   req_src2    in   NREQ*32   operand 2 per requester
//   rsp_valid   out  NREQ      one-hot; result held for requester i
//   rsp_ready   in   NREQ      requester i consumes result
//   rsp_data    out  32        held result (shared by all requesters)
//   alu_ctrl    out  4         to ALU op select
//   alu_src1    out  32        to ALU operand 1
//   alu_src2    out  32        to ALU operand 2
//   alu_out     in   32        from ALU result (combinational)
//   busy        out  1         result buffer occupied
// BEHAVIOUR
//   Reset: state=IDLE, rsp_valid=0, rsp_data=0, owner=0, busy=0, last_grant=(RR_RESET+NREQ-1)%NREQ.
//   States: IDLE (buffer empty), HOLD (buffer full, rsp_valid[owner]=1).
//   can_accept = !flush && (state==IDLE || (state==HOLD && rsp_ready[owner])).
//   Grant: g = first i with req_valid[i] scanning last_grant+1, +2, ... mod NREQ.
//   req_ready[g]=can_accept && req_valid[g]; all other req_ready=0. req_ready may depend on req_valid.
//   ALU inputs = slice g when any req_valid; else alu_ctrl=4'b0000, alu_src1=alu_src2=0.
//   Accept (req_ready[g]=1): rsp_data<=alu_out, owner<=g, last_grant<=g, state<=HOLD.
//   Latency: accept cycle N -> rsp_valid[g]=1 with result from cycle N+1.
//   HOLD: rsp_data/owner stable until consumed; rsp_ready of non-owners ignored.
//   HOLD & rsp_ready[owner] & no accept -> IDLE, rsp_valid=0.
//   HOLD & rsp_ready[owner] & accept -> stay HOLD with new data/owner (back-to-back, 1 op/cycle).
//   flush=1: state<=IDLE, rsp_valid<=0, no accept, last_grant unchanged; rsp_data keeps value.
//   req_valid dropped without ready: no state change, grant re-evaluated next cycle.
//   busy = (state==HOLD). rsp_valid one-hot or zero at all times.
//   Async reset mid-HOLD: result lost, outputs to reset values immediately.
// TESTING
//   T1 reset, req0 ctrl=0000 src1=5 src2=3 -> req_ready=01, next cycle rsp_valid=01 rsp_data=8.
//   T2 req0 & req1 always valid, rsp_ready=11: grants alternate 0,1,0,1; req0 sub 10-4=6, req1 slt -1<1 -> 1.
//   T3 HOLD for req1 (or 0xF0|0x0F=0xFF), rsp_ready=00 for 3 cycles -> req_ready=00, rsp_data=0xFF stable.
//   T4 HOLD, rsp_ready[owner]=1 with req0 valid xor 0xAA^0xFF -> same-cycle accept, next rsp_data=0x55, busy=1.
//   T5 HOLD + flush=1 with req valid -> req_ready=00, next cycle IDLE, rsp_valid=0, then normal accept.
//   T6 rst_n low during HOLD -> rsp_valid=0, busy=0 async; after release req1&req0 valid -> req0 granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU between NREQ requesters.
// The granted operation's ALU result is captured into a single result buffer held until consumed.
module alu_share_arbiter #(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned RR_RESET = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*4-1:0]    req_ctrl,
   input  logic [NREQ*32-1:0]   req_src1,
   input  logic [NREQ*32-1:0]   req_src2,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_data,
   output logic [3:0]           alu_ctrl,
   output logic [31:0]          alu_src1,
   output logic [31:0]          alu_src2,
   input  logic [31:0]          alu_out,
   output logic                 busy
);

   localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned XW       = IW + 1;
   localparam int unsigned LastInit = (RR_RESET + NREQ - 1) % NREQ;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StHold = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] last_q, last_d;
   logic [31:0]   data_q, data_d;
   logic [IW-1:0] grant;
   logic [XW-1:0] idx;
   logic          any_valid;
   logic          can_accept;
   logic          accept;

   assign any_valid = |req_valid;

   // Scan from the farthest offset down so the nearest valid requester after last_q wins.
   always_comb begin
      grant = last_q;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = {1'b0, last_q} + XW'(k);
         if (idx >= XW'(NREQ)) begin
            idx = idx - XW'(NREQ);
         end
         if (req_valid[idx[IW-1:0]]) begin
            grant = idx[IW-1:0];
         end
      end
   end

   always_comb begin
      alu_ctrl = '0;
      alu_src1 = '0;
      alu_src2 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (any_valid && grant == IW'(i)) begin
            alu_ctrl = req_ctrl[i*4 +: 4];
            alu_src1 = req_src1[i*32 +: 32];
            alu_src2 = req_src2[i*32 +: 32];
         end
      end
   end

   assign can_accept = !flush && ((state_q == StIdle) || rsp_ready[owner_q]);
   assign accept     = can_accept && any_valid;
   assign req_ready  = accept ? (NREQ'(1) << grant) : '0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      data_d  = data_q;
      if (flush) begin
         state_d = StIdle;
      end else if (accept) begin
         state_d = StHold;
         owner_d = grant;
         last_d  = grant;
         data_d  = alu_out;
      end else if (state_q == StHold && rsp_ready[owner_q]) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= IW'(LastInit);
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign busy      = (state_q == StHold);
   assign rsp_valid = busy ? (NREQ'(1) << owner_q) : '0;
   assign rsp_data  = data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, reset corner case, then random traffic
// checked against a round-robin/result-buffer reference model.
module tb_alu_share_arbiter;

   localparam int NREQ = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*4-1:0] req_ctrl = '0;
   logic [NREQ*32-1:0] req_src1 = '0;
   logic [NREQ*32-1:0] req_src2 = '0;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready = '0;
   logic [31:0]       rsp_data;
   logic [3:0]        alu_ctrl;
   logic [31:0]       alu_src1;
   logic [31:0]       alu_src2;
   logic [31:0]       alu_out;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit          m_hold;
   int          m_owner;
   int          m_last;
   logic [31:0] m_data;
   bit          nx_hold;
   int          nx_owner;
   int          nx_last;
   logic [31:0] nx_data;

   typedef struct {
      logic [1:0]  rv;
      logic [3:0]  c0;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [3:0]  c1;
      logic [31:0] a1;
      logic [31:0] b1;
      logic [1:0]  rr;
      logic        fl;
      logic [1:0]  e_rdy;
      logic [1:0]  e_rv;
      logic [31:0] e_data;
      logic        e_busy;
   } vec_t;

   vec_t tbl[13];

   always #5 clk = ~clk;

   // Environment ALU: 0 add, 1 sub, 2 signed slt, 3 or, 4 xor, 5 and.
   function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
      case (c)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a & b;
         default: return a;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_ctrl, alu_src1, alu_src2);

   alu_share_arbiter #(.NREQ(NREQ), .RR_RESET(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ctrl  (req_ctrl),
      .req_src1  (req_src1),
      .req_src2  (req_src2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .alu_ctrl  (alu_ctrl),
      .alu_src1  (alu_src1),
      .alu_src2  (alu_src2),
      .alu_out   (alu_out),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hold  = 1'b0;
      m_owner = 0;
      m_last  = NREQ - 1;
      m_data  = '0;
   endtask

   function automatic int model_grant();
      for (int d = 1; d <= NREQ; d++) begin
         int i;
         i = (m_last + d) % NREQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic apply(input vec_t v);
      req_valid = v.rv;
      req_ctrl  = {v.c1, v.c0};
      req_src1  = {v.a1, v.a0};
      req_src2  = {v.b1, v.b0};
      rsp_ready = v.rr;
      flush     = v.fl;
   endtask

   // Checks combinational outputs mid-cycle and computes the model's next state.
   task automatic pre_edge();
      int          g;
      bit          can;
      logic [31:0] e_rdy;
      logic [3:0]  e_c;
      logic [31:0] e_a;
      logic [31:0] e_b;
      #2;
      g   = model_grant();
      can = !flush && (!m_hold || rsp_ready[m_owner]);
      e_rdy = (can && g >= 0) ? (32'd1 << g) : 32'd0;
      e_c = 4'd0;
      e_a = '0;
      e_b = '0;
      if (g >= 0) begin
         e_c = req_ctrl[g*4 +: 4];
         e_a = req_src1[g*32 +: 32];
         e_b = req_src2[g*32 +: 32];
      end
      check("req_ready", 32'(req_ready), e_rdy);
      check("alu_ctrl", 32'(alu_ctrl), 32'(e_c));
      check("alu_src1", alu_src1, e_a);
      check("alu_src2", alu_src2, e_b);
      nx_hold  = m_hold;
      nx_owner = m_owner;
      nx_last  = m_last;
      nx_data  = m_data;
      if (flush) begin
         nx_hold = 1'b0;
      end else if (can && g >= 0) begin
         nx_hold  = 1'b1;
         nx_owner = g;
         nx_last  = g;
         nx_data  = alu_fn(e_c, e_a, e_b);
      end else if (m_hold && rsp_ready[m_owner]) begin
         nx_hold = 1'b0;
      end
   endtask

   task automatic post_edge();
      @(posedge clk);
      m_hold  = nx_hold;
      m_owner = nx_owner;
      m_last  = nx_last;
      m_data  = nx_data;
      #1;
      check("rsp_valid", 32'(rsp_valid), m_hold ? (32'd1 << m_owner) : 32'd0);
      check("rsp_data", rsp_data, m_data);
      check("busy", 32'(busy), 32'(m_hold));
   endtask

   initial begin
      vec_t v;
      //             rv     c0 a0          b0          c1 a1            b1        rr     fl    rdy    rv     data         busy
      tbl[0]  = '{2'b01, 4'd0, 32'd5,  32'd3,  4'd0, 32'd0,        32'd0,  2'b00, 1'b0, 2'b01, 2'b01, 32'd8,   1'b1};
      tbl[1]  = '{2'b11, 4'd1, 32'd10, 32'd4,  4'd2, 32'hFFFFFFFF, 32'd1,  2'b11, 1'b0, 2'b10, 2'b10, 32'd1,   1'b1};
      tbl[2]  = '{2'b11, 4'd1, 32'd10, 32'd4,  4'd2, 32'hFFFFFFFF, 32'd1,  2'b11, 1'b0, 2'b01, 2'b01, 32'd6,   1'b1};
      tbl[3]  = '{2'b11, 4'd1, 32'd10, 32'd4,  4'd2, 32'hFFFFFFFF, 32'd1,  2'b11, 1'b0, 2'b10, 2'b10, 32'd1,   1'b1};
      tbl[4]  = '{2'b10, 4'd1, 32'd10, 32'd4,  4'd3, 32'hF0,       32'h0F, 2'b10, 1'b0, 2'b10, 2'b10, 32'hFF,  1'b1};
      tbl[5]  = '{2'b11, 4'd4, 32'hAA, 32'hFF, 4'd3, 32'hF0,       32'h0F, 2'b00, 1'b0, 2'b00, 2'b10, 32'hFF,  1'b1};
      tbl[6]  = '{2'b11, 4'd4, 32'hAA, 32'hFF, 4'd3, 32'hF0,       32'h0F, 2'b01, 1'b0, 2'b00, 2'b10, 32'hFF,  1'b1};
      tbl[7]  = '{2'b11, 4'd4, 32'hAA, 32'hFF, 4'd3, 32'hF0,       32'h0F, 2'b00, 1'b0, 2'b00, 2'b10, 32'hFF,  1'b1};
      tbl[8]  = '{2'b01, 4'd4, 32'hAA, 32'hFF, 4'd3, 32'hF0,       32'h0F, 2'b10, 1'b0, 2'b01, 2'b01, 32'h55,  1'b1};
      tbl[9]  = '{2'b11, 4'd4, 32'hAA, 32'hFF, 4'd3, 32'hF0,       32'h0F, 2'b00, 1'b1, 2'b00, 2'b00, 32'h55,  1'b0};
      tbl[10] = '{2'b11, 4'd4, 32'hAA, 32'hFF, 4'd3, 32'hF0,       32'h0F, 2'b00, 1'b0, 2'b10, 2'b10, 32'hFF,  1'b1};
      tbl[11] = '{2'b00, 4'd0, 32'd0,  32'd0,  4'd0, 32'd0,        32'd0,  2'b10, 1'b0, 2'b00, 2'b00, 32'hFF,  1'b0};
      tbl[12] = '{2'b00, 4'd0, 32'd0,  32'd0,  4'd0, 32'd0,        32'd0,  2'b00, 1'b0, 2'b00, 2'b00, 32'hFF,  1'b0};

      model_reset();
      #1;
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset rsp_data", rsp_data, 32'd0);
      check("reset req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed table
      for (int r = 0; r < 13; r++) begin
         apply(tbl[r]);
         pre_edge();
         check($sformatf("tbl%0d req_ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
         post_edge();
         check($sformatf("tbl%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].e_rv));
         check($sformatf("tbl%0d rsp_data", r), rsp_data, tbl[r].e_data);
         check($sformatf("tbl%0d busy", r), 32'(busy), 32'(tbl[r].e_busy));
      end

      // Async reset in the middle of HOLD
      v = '{2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 32'd7, 32'd8, 2'b00, 1'b0, 2'b10, 2'b10, 32'd15, 1'b1};
      apply(v);
      pre_edge();
      post_edge();
      check("pre-reset rsp_data", rsp_data, 32'd15);
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async rsp_valid", 32'(rsp_valid), 32'd0);
      check("async busy", 32'(busy), 32'd0);
      check("async rsp_data", rsp_data, 32'd0);
      @(posedge clk);
      #1;
      check("in-reset busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      v = '{2'b11, 4'd0, 32'd1, 32'd2, 4'd1, 32'd9, 32'd4, 2'b00, 1'b0, 2'b01, 2'b01, 32'd3, 1'b1};
      apply(v);
      pre_edge();
      check("post-reset grant", 32'(req_ready), 32'd1);
      post_edge();
      check("post-reset rsp_data", rsp_data, 32'd3);
      check("post-reset rsp_valid", 32'(rsp_valid), 32'd1);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         req_valid = NREQ'($urandom_range(0, 3));
         for (int i = 0; i < NREQ; i++) begin
            req_ctrl[i*4 +: 4]  = 4'($urandom_range(0, 5));
            req_src1[i*32 +: 32] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
            req_src2[i*32 +: 32] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
         end
         rsp_ready = NREQ'($urandom_range(0, 3));
         flush     = ($urandom_range(0, 7) == 0);
         pre_edge();
         post_edge();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
